// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// Module  : irq_controller
// Brief   : Edge-latched, masked, fixed-priority interrupt controller with
//           request / ack / end-of-interrupt handshake toward the CPU.
// Revision: 1.0
// ============================================================================
module irq_controller #(
    parameter int                 NUM_IRQ   = 3,
    parameter int                 VEC_W     = 2,
    parameter logic [NUM_IRQ-1:0] SYNC_MASK = 3'b110
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               gie,
    input  logic               irq_ack,
    input  logic               irq_eoi,
    output logic               irq_req,
    output logic [VEC_W-1:0]   irq_vec,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] mask,
    output logic               in_service
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQUEST = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [1:0]         r_warm;
    logic [NUM_IRQ-1:0] r_hist, r_armed, r_pending, r_mask;
    logic [NUM_IRQ-1:0] w_synced, w_valid, w_rise, w_elig, w_ack_clr;
    logic               r_req, w_req_nxt, r_insvc, w_insvc_nxt;
    logic [VEC_W-1:0]   r_vec, w_vec_nxt, w_win_idx;
    logic               w_any_elig, w_frozen_elig;

    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_src
            if (SYNC_MASK[gi]) begin : g_sync
                logic r_s1, r_s2;
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_s1 <= 1'b0;
                        r_s2 <= 1'b0;
                    end else begin
                        r_s1 <= irq_in[gi];
                        r_s2 <= r_s1;
                    end
                end
                assign w_synced[gi] = r_s2;
                // Synchronizer output only reflects the pin once both stages refilled after reset.
                assign w_valid[gi]  = r_warm[1];
            end else begin : g_direct
                assign w_synced[gi] = irq_in[gi];
                assign w_valid[gi]  = 1'b1;
            end
        end
    endgenerate

    // A line must be seen low after reset before its rise counts, so a pin
    // still held high across reset does not fire again.
    assign w_rise     = w_synced & ~r_hist & r_armed;
    assign w_elig     = gie ? (r_pending & r_mask) : '0;
    assign w_any_elig = |w_elig;

    always_comb begin
        w_win_idx     = '0;
        w_frozen_elig = 1'b0;
        w_ack_clr     = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_elig[i])
                w_win_idx = VEC_W'(i);
            if (r_vec == VEC_W'(i)) begin
                w_frozen_elig = w_elig[i];
                if (r_state == S_REQUEST && irq_ack)
                    w_ack_clr[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_warm    <= 2'b00;
            r_hist    <= '0;
            r_armed   <= '0;
            r_pending <= '0;
            r_mask    <= '0;
        end else begin
            r_warm    <= {r_warm[0], 1'b1};
            r_hist    <= w_synced;
            r_armed   <= r_armed | (w_valid & ~w_synced);
            r_pending <= (r_pending & ~w_ack_clr) | w_rise;
            if (mask_we)
                r_mask <= mask_wdata;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_insvc_nxt = r_insvc;
        w_vec_nxt   = r_vec;
        case (r_state)
            S_IDLE: begin
                if (w_any_elig) begin
                    w_vec_nxt   = w_win_idx;
                    w_req_nxt   = 1'b1;
                    w_state_nxt = S_REQUEST;
                end
            end
            S_REQUEST: begin
                if (irq_ack) begin
                    w_req_nxt   = 1'b0;
                    w_insvc_nxt = 1'b1;
                    w_state_nxt = S_SERVICE;
                end else if (!w_frozen_elig) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            S_SERVICE: begin
                if (irq_eoi) begin
                    w_insvc_nxt = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_insvc_nxt = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_insvc <= 1'b0;
            r_vec   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_insvc <= w_insvc_nxt;
            r_vec   <= w_vec_nxt;
        end
    end

    assign irq_req    = r_req;
    assign irq_vec    = r_vec;
    assign pending    = r_pending;
    assign mask       = r_mask;
    assign in_service = r_insvc;

endmodule
`default_nettype wire

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt controller between the interrupt sources (bit 0 = timer output, bits 2:1 = external interrupt pins) and the CPU interrupt port.
- Latches rising edges into pending bits, applies a per-source mask and a global enable, and picks the highest-priority source by fixed priority.
- Presents one request plus vector to the CPU and holds it through an ack / end-of-interrupt handshake.
- Tracks the source in service so nested requests are blocked until EOI.

Parameters:
- NUM_IRQ, 3, number of interrupt sources (1..4).
- VEC_W, 2, width of the vector output; must satisfy 2**VEC_W >= NUM_IRQ.
- SYNC_MASK, 3'b110, per-source flag; 1 = input passes through a 2-flop synchronizer (asynchronous external pin), 0 = input is already in the clk domain.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- irq_in  in  NUM_IRQ  raw interrupt lines, bit 0 = timer.
- mask_we  in  1  write strobe for the mask register.
- mask_wdata  in  NUM_IRQ  new mask value; 1 = source enabled.
- gie  in  1  global interrupt enable from the CPU.
- irq_ack  in  1  one-cycle CPU acknowledge of the current request.
- irq_eoi  in  1  one-cycle end-of-interrupt from the CPU (return from ISR).
- irq_req  out  1  interrupt request to the CPU.
- irq_vec  out  VEC_W  index of the requesting or in-service source.
- pending  out  NUM_IRQ  pending register, for status reads.
- mask  out  NUM_IRQ  current mask register.
- in_service  out  1  an ISR is active.

Behaviour:
- Reset values (after a clk edge with reset=1):
  - pending=0, mask=0, irq_req=0, irq_vec=0, in_service=0.
  - Synchronizer and edge-detect history flops = 0.
  - FSM = IDLE.
  - reset dominates every other input in the same cycle.
- Input path:
  - Per source: optional 2-flop synchronizer per SYNC_MASK, then edge history flop.
  - Rising edge = current synced value 1 and history 0.
  - A level held high produces exactly one edge.
- Pending bit update, per source, per cycle:
  - Set on rising edge.
  - Cleared when irq_ack is high in REQUEST and the source equals irq_vec.
  - Edge on the same source in the same cycle as its ack: pending stays 1 (set wins).
- Edge detection runs while masked; a masked source still accumulates pending.
- Mask register:
  - mask <= mask_wdata on mask_we.
  - The new value is used by the arbiter from the next cycle.
- Eligible = pending & mask, qualified by gie.
  - Priority: lowest index wins (timer highest).
- FSM:
  - IDLE:
    - If gie and any eligible bit: irq_vec <= winner index, irq_req <= 1, go to REQUEST.
  - REQUEST (irq_req=1, irq_vec frozen):
    - irq_ack: irq_req <= 0, in_service <= 1, clear that pending bit, go to SERVICE.
    - Else, if the frozen source becomes ineligible (masked or gie=0): irq_req <= 0, go to IDLE; the pending bit is kept.
    - A higher-priority source arriving in REQUEST does not replace the vector.
  - SERVICE (in_service=1, irq_vec holds the serviced index, irq_req=0):
    - No new request is issued regardless of pending.
    - irq_eoi: in_service <= 0, go to IDLE.
    - A pending source can be requested again 1 cycle after leaving SERVICE.
  - irq_ack outside REQUEST and irq_eoi outside SERVICE are ignored.
- Latency, unsynchronized source:
  - irq_in rises and is sampled at edge N.
  - pending visible after N.
  - irq_req high after edge N+1.
  - Synchronized sources add 2 cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- Target size: about 150–250 lines of RTL.

Test Plan:
- Timer pulse, mask=3'b001, gie=1, no ack:
  - pending=001 one cycle after the sampled edge; irq_req=1, irq_vec=0 one cycle later.
  - irq_req held until ack.
- Simultaneous edges on sources 1 and 2 (synced), mask=3'b111:
  - First request has irq_vec=1.
  - After ack then eoi, a second request with irq_vec=2.
  - pending sequence 110 -> 100 -> 000.
- Source 0 edge while mask=000:
  - pending=001, no irq_req.
  - Write mask_wdata=001: irq_req rises 1 cycle after the mask update is visible.
- In REQUEST on vec 0, a new source-0 edge in the same cycle as irq_ack:
  - pending[0] stays 1, FSM goes to SERVICE.
  - After eoi, a new request with vec 0.
- In REQUEST, drive gie=0:
  - irq_req drops next cycle, pending kept.
  - gie=1 restores the request.
- reset=1 pulsed in SERVICE with pending=110:
  - All outputs 0 and FSM IDLE on the next edge.
  - Inputs held high do not re-trigger until they go low and then high again.
